line_fill_ctrl: RTL and testbench

//  Burst master that sits directly upstream of the data memory. Accepts one cache-line

---
 rtl/line_fill_ctrl.sv | 128 ++++++++++++
 tb/tb_line_fill_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_ctrl.sv
// line_fill_ctrl: burst master between a cache-line requester and the data memory.
// One request becomes one sz_4word/sz_8word burst; the line returns over valid/ready.
module line_fill_ctrl #(
    parameter int LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [31:0]             req_addr,
    input  logic                    req_wr,
    input  logic [32*LINE_WORDS-1:0] req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [32*LINE_WORDS-1:0] resp_rdata,
    output logic                    proto_err,
    output logic                    mem_enable,
    output logic [31:0]             mem_addr,
    output logic [1:0]              mem_access_size,
    output logic                    mem_rd_wr,
    output logic [31:0]             mem_data_in,
    input  logic [31:0]             mem_data_out,
    input  logic                    mem_busy
);
    localparam logic [1:0] SZ_4WORD = 2'b01;
    localparam logic [1:0] SZ_8WORD = 2'b10;
    localparam logic [1:0] LINE_SIZE = (LINE_WORDS == 8) ? SZ_8WORD : SZ_4WORD;
    localparam int BW = $clog2(LINE_WORDS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
    localparam logic [31:0] LINE_MASK = ~32'(LINE_WORDS * 4 - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BURST, DONE} state_t;

    state_t state, next_state;
    logic [31:0] line_addr;
    logic wr;
    logic [LINE_WORDS-1:0][31:0] wdata;
    logic [LINE_WORDS-1:0][31:0] line_buf;
    logic [BW-1:0] beat;
    logic [BW-1:0] start_beat;

    // Word 0 of a write goes out with the command, so the write burst starts at beat 1.
    assign start_beat = wr ? BW'(1) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = ISSUE;
            ISSUE:   next_state = BURST;
            BURST:   if (beat == LAST_BEAT) next_state = DONE;
            DONE:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_addr <= '0;
            wr        <= 1'b0;
            wdata     <= '0;
            line_buf  <= '0;
            beat      <= '0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        line_addr <= req_addr & LINE_MASK;
                        wr        <= req_wr;
                        wdata     <= req_wdata;
                    end
                end
                ISSUE: beat <= start_beat;
                BURST: begin
                    if (!wr) line_buf[beat] <= mem_data_out;
                    beat <= beat + BW'(1);
                end
                default: ;
            endcase
            // Memory must stay busy for the whole burst once it has taken the command.
            if (state == BURST && mem_enable && !mem_busy && beat != start_beat) begin
                proto_err <= 1'b1;
            end
        end
    end

    always_comb begin
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = '0;
        mem_enable      = 1'b0;
        mem_addr        = '0;
        mem_access_size = '0;
        mem_rd_wr       = 1'b0;
        mem_data_in     = '0;
        case (state)
            IDLE: req_ready = !reset;
            ISSUE: begin
                mem_enable      = 1'b1;
                mem_addr        = line_addr;
                mem_access_size = LINE_SIZE;
                mem_rd_wr       = !wr;
                mem_data_in     = wdata[0];
            end
            BURST: begin
                // Dropping enable on the last read capture keeps memory from restarting.
                mem_enable      = wr || (beat != LAST_BEAT);
                mem_addr        = line_addr;
                mem_access_size = LINE_SIZE;
                mem_rd_wr       = !wr;
                if (wr) mem_data_in = wdata[beat];
            end
            DONE: begin
                resp_valid = 1'b1;
                if (!wr) resp_rdata = line_buf;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_line_fill_ctrl.sv
// Bench for line_fill_ctrl: a 4-word and an 8-word instance, each with a burst memory model;
// expected lines are queued when a request is issued and checked when resp_valid rises.
module tb_line_fill_ctrl;
    localparam logic [1:0] SZ4 = 2'b01;
    localparam logic [1:0] SZ8 = 2'b10;

    logic clk, reset, kill_busy;

    logic a_req_valid, a_req_ready, a_req_wr, a_resp_valid, a_resp_ready, a_proto_err;
    logic a_mem_enable, a_mem_rd_wr, a_mem_busy;
    logic [31:0] a_req_addr, a_mem_addr, a_mem_data_in, a_mem_data_out;
    logic [1:0] a_mem_access_size;
    logic [127:0] a_req_wdata, a_resp_rdata;

    logic b_req_valid, b_req_ready, b_req_wr, b_resp_valid, b_resp_ready, b_proto_err;
    logic b_mem_enable, b_mem_rd_wr, b_mem_busy;
    logic [31:0] b_req_addr, b_mem_addr, b_mem_data_in, b_mem_data_out;
    logic [1:0] b_mem_access_size;
    logic [255:0] b_req_wdata, b_resp_rdata;

    typedef struct {
        logic [255:0] data;
        int lat;
        string tag;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] ref_a [64];
    logic [31:0] ref_b [64];
    int n_cmp = 0;
    int n_err = 0;

    line_fill_ctrl #(.LINE_WORDS(4)) dut_a (
        .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_addr(a_req_addr), .req_wr(a_req_wr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_rdata(a_resp_rdata),
        .proto_err(a_proto_err), .mem_enable(a_mem_enable), .mem_addr(a_mem_addr),
        .mem_access_size(a_mem_access_size), .mem_rd_wr(a_mem_rd_wr),
        .mem_data_in(a_mem_data_in), .mem_data_out(a_mem_data_out), .mem_busy(a_mem_busy)
    );

    line_fill_ctrl #(.LINE_WORDS(8)) dut_b (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(b_req_addr), .req_wr(b_req_wr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
        .proto_err(b_proto_err), .mem_enable(b_mem_enable), .mem_addr(b_mem_addr),
        .mem_access_size(b_mem_access_size), .mem_rd_wr(b_mem_rd_wr),
        .mem_data_in(b_mem_data_in), .mem_data_out(b_mem_data_out), .mem_busy(b_mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i >= 4 && i < 8) return 32'h11111111 * 32'(i - 3);
        if (i >= 16 && i < 24) return 32'hB0B00000 + 32'(i);
        return '0;
    endfunction

    // Burst memory model: command on enable while idle, registered read beats, abort on enable drop.
    logic [31:0] mem_a [64];
    logic a_mbusy, a_mrd;
    logic [5:0] a_midx;
    int a_mcnt, a_mlen;
    always @(posedge clk) begin
        if (reset) begin
            a_mbusy <= 1'b0;
            for (int i = 0; i < 64; i++) mem_a[i] <= init_word(i);
        end else if (a_mbusy && !a_mem_enable) begin
            a_mbusy <= 1'b0;
        end else if (a_mbusy) begin
            if (a_mrd) a_mem_data_out <= mem_a[a_midx + 6'(a_mcnt)];
            else mem_a[a_midx + 6'(a_mcnt)] <= a_mem_data_in;
            a_mcnt <= a_mcnt + 1;
            if (a_mcnt == a_mlen - 1) a_mbusy <= 1'b0;
        end else if (a_mem_enable) begin
            a_midx  <= a_mem_addr[7:2];
            a_mrd   <= a_mem_rd_wr;
            a_mlen  <= (a_mem_access_size == SZ8) ? 8 : 4;
            a_mcnt  <= 1;
            a_mbusy <= 1'b1;
            if (a_mem_rd_wr) a_mem_data_out <= mem_a[a_mem_addr[7:2]];
            else mem_a[a_mem_addr[7:2]] <= a_mem_data_in;
        end
    end
    assign a_mem_busy = a_mbusy;

    logic [31:0] mem_b [64];
    logic b_mbusy, b_mrd;
    logic [5:0] b_midx;
    int b_mcnt, b_mlen;
    always @(posedge clk) begin
        if (reset) begin
            b_mbusy <= 1'b0;
            for (int i = 0; i < 64; i++) mem_b[i] <= init_word(i);
        end else if (b_mbusy && !b_mem_enable) begin
            b_mbusy <= 1'b0;
        end else if (b_mbusy) begin
            if (b_mrd) b_mem_data_out <= mem_b[b_midx + 6'(b_mcnt)];
            else mem_b[b_midx + 6'(b_mcnt)] <= b_mem_data_in;
            b_mcnt <= b_mcnt + 1;
            if (b_mcnt == b_mlen - 1) b_mbusy <= 1'b0;
        end else if (b_mem_enable) begin
            b_midx  <= b_mem_addr[7:2];
            b_mrd   <= b_mem_rd_wr;
            b_mlen  <= (b_mem_access_size == SZ8) ? 8 : 4;
            b_mcnt  <= 1;
            b_mbusy <= 1'b1;
            if (b_mem_rd_wr) b_mem_data_out <= mem_b[b_mem_addr[7:2]];
            else mem_b[b_mem_addr[7:2]] <= b_mem_data_in;
        end
    end
    assign b_mem_busy = b_mbusy & ~kill_busy;

    function automatic logic [255:0] rdata_of(input bit b);
        return b ? b_resp_rdata : 256'(a_resp_rdata);
    endfunction

    function automatic logic [1:0] flags_of(input bit b);
        return b ? {b_resp_valid, b_req_ready} : {a_resp_valid, a_req_ready};
    endfunction

    function automatic logic [35:0] issue_of(input bit b);
        return b ? {b_mem_enable, b_mem_rd_wr, b_mem_access_size, b_mem_addr}
                 : {a_mem_enable, a_mem_rd_wr, a_mem_access_size, a_mem_addr};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit b, input logic wr, input logic [31:0] addr,
                                 input logic [255:0] wd, input string tag);
        exp_t e;
        int lw;
        int n;
        int idx;
        logic [31:0] base;
        lw   = b ? 8 : 4;
        base = addr & ~(32'(lw * 4) - 32'd1);
        idx  = int'(base[7:2]);
        e.tag  = tag;
        e.data = '0;
        e.lat  = wr ? lw : lw + 1;
        for (int k = 0; k < lw; k++) begin
            if (wr) begin
                if (b) ref_b[idx + k] = wd[32*k +: 32];
                else   ref_a[idx + k] = wd[32*k +: 32];
            end else begin
                e.data[32*k +: 32] = b ? ref_b[idx + k] : ref_a[idx + k];
            end
        end
        if (b) begin
            b_req_wr = wr; b_req_addr = addr; b_req_wdata = wd; b_req_valid = 1'b1;
        end else begin
            a_req_wr = wr; a_req_addr = addr; a_req_wdata = wd[127:0]; a_req_valid = 1'b1;
        end
        exp_q.push_back(e);
        n = 0;
        while (flags_of(b) != 2'b01 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " req_ready"}, 256'(flags_of(b)), 256'(2'b01));
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        check({tag, " issue"}, 256'(issue_of(b)), 256'({1'b1, ~wr, (b ? SZ8 : SZ4), base}));
    endtask

    task automatic checkOutput(input bit b, input int start_lat, input int hold);
        exp_t e;
        int lat;
        lat = start_lat;
        while (flags_of(b) != 2'b10 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (exp_q.size() == 0) begin
            e.tag = "missing"; e.data = '1; e.lat = -1;
        end else begin
            e = exp_q.pop_front();
        end
        check({e.tag, " latency"}, 256'(lat), 256'(e.lat));
        check({e.tag, " rdata"}, rdata_of(b), e.data);
        check({e.tag, " done mem_enable"}, 256'(b ? b_mem_enable : a_mem_enable), '0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({e.tag, " hold"}, {flags_of(b), rdata_of(b)}, {2'b10, e.data});
        end
        @(negedge clk);
        if (b) b_resp_ready = 1'b1; else a_resp_ready = 1'b1;
        @(posedge clk); #1;
        a_resp_ready = 1'b0;
        b_resp_ready = 1'b0;
        check({e.tag, " release"}, 256'(flags_of(b)), 256'(2'b01));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [255:0] wd;
        reset = 1'b1; kill_busy = 1'b0;
        a_req_valid = 0; a_req_wr = 0; a_req_addr = '0; a_req_wdata = '0; a_resp_ready = 0;
        b_req_valid = 0; b_req_wr = 0; b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 0;
        for (int i = 0; i < 64; i++) begin
            ref_a[i] = init_word(i);
            ref_b[i] = init_word(i);
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", 256'({a_req_ready, a_resp_valid, a_resp_rdata, a_proto_err, a_mem_enable,
              a_mem_addr, a_mem_access_size, a_mem_rd_wr, a_mem_data_in}), '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle after reset", 256'({a_req_ready, a_resp_valid, a_proto_err}), 256'(3'b100));

        applyStimulus(0, 1'b0, 32'h80020010, '0, "t1 read");
        checkOutput(0, 0, 0);

        wd = '0;
        for (int i = 0; i < 4; i++) wd[32*i +: 32] = 32'hA0000000 + 32'(i);
        applyStimulus(0, 1'b1, 32'h80020020, wd, "t2 write");
        checkOutput(0, 0, 0);
        check("t2 memory words", 256'({mem_a[11], mem_a[10], mem_a[9], mem_a[8]}), 256'(wd[127:0]));
        applyStimulus(0, 1'b0, 32'h80020020, '0, "t2 readback");
        checkOutput(0, 0, 0);

        applyStimulus(0, 1'b0, 32'h80020014, '0, "t3 unaligned");
        checkOutput(0, 0, 0);

        applyStimulus(0, 1'b0, 32'h80020010, '0, "t4 held");
        a_req_wr = 1'b0; a_req_addr = 32'h80020020; a_req_valid = 1'b1;
        checkOutput(0, 0, 3);
        applyStimulus(0, 1'b0, 32'h80020020, '0, "t4 queued");
        checkOutput(0, 0, 0);

        applyStimulus(0, 1'b0, 32'h80020010, '0, "t5 aborted");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("t5 outputs in reset", 256'({a_req_ready, a_resp_valid, a_resp_rdata, a_mem_enable,
              a_mem_addr, a_mem_access_size, a_mem_rd_wr, a_mem_data_in}), '0);
        void'(exp_q.pop_back());
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        applyStimulus(0, 1'b0, 32'h80020010, '0, "t5 repeat");
        checkOutput(0, 0, 0);
        check("t5 proto_err", 256'(a_proto_err), '0);

        applyStimulus(1, 1'b0, 32'h80020040, '0, "t6 read8");
        checkOutput(1, 0, 0);
        check("t6 proto_err clean", 256'(b_proto_err), '0);
        applyStimulus(1, 1'b0, 32'h80020040, '0, "t6 busy drop");
        repeat (4) @(posedge clk);
        #1 kill_busy = 1'b1;
        @(posedge clk);
        #1 kill_busy = 1'b0;
        check("t6 proto_err set", 256'(b_proto_err), 256'(1'b1));
        checkOutput(1, 5, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t6 proto_err sticky", 256'(b_proto_err), 256'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
